// File: rtl/lsu_mem_port.sv
// Memory-side load/store port: accepts one MEM-stage access, runs a variable-latency
// memory handshake, lane-aligns stores and extends/merges loads back to the register file.
module lsu_mem_port #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  sl_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rt_old,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        addr_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        maddr_q, maddr_d;
  logic [31:0]        mwdata_q, mwdata_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [1:0]         k_q, k_d;
  logic [31:0]        rt_q, rt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               addr_err_q, addr_err_d;
  logic               bus_err_q, bus_err_d;

  logic               req_act, misalign, accept;
  logic [1:0]         k;
  logic [3:0]         st_be;
  logic [31:0]        st_data;
  logic [4:0]         sh, shinv;
  logic [31:0]        rsh, ld_val;

  assign k        = addr[1:0];
  assign req_act  = req_valid && (sl_ctrl != 3'd0);
  assign misalign = ((sl_ctrl == 3'd1) && (k != 2'b00)) ||
                    (((sl_ctrl == 3'd2) || (sl_ctrl == 3'd6)) && k[0]);
  assign accept   = (state_q == IDLE) && req_act && !misalign;

  // Store lane steering; the unsigned codes have no store meaning and fall back to half/byte.
  always_comb begin
    st_be   = 4'b1111;
    st_data = 32'h0;
    if (req_we) begin
      case (sl_ctrl)
        3'd1: st_data = wdata;
        3'd2, 3'd6: begin
          st_be   = 4'b0011 << k;
          st_data = {2{wdata[15:0]}};
        end
        3'd3, 3'd7: begin
          st_be   = 4'b0001 << k;
          st_data = {4{wdata[7:0]}};
        end
        3'd4: begin
          st_be   = 4'b1111 >> (~k);
          st_data = wdata >> {~k, 3'b000};
        end
        3'd5: begin
          st_be   = 4'b1111 << k;
          st_data = wdata << {k, 3'b000};
        end
        default: st_data = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    be_d       = be_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    ctrl_d     = ctrl_q;
    k_d        = k_q;
    rt_d       = rt_q;
    rdata_d    = rdata_q;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_act && misalign) begin
          addr_err_d = 1'b1;
        end else if (accept) begin
          state_d  = ACCESS;
          cnt_d    = '0;
          we_d     = req_we;
          be_d     = st_be;
          maddr_d  = {addr[31:2], 2'b00};
          mwdata_d = st_data;
          ctrl_d   = sl_ctrl;
          k_d      = k;
          rt_d     = rt_old;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          bus_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= 4'b0;
      maddr_q    <= 32'h0;
      mwdata_q   <= 32'h0;
      ctrl_q     <= 3'd0;
      k_q        <= 2'b0;
      rt_q       <= 32'h0;
      rdata_q    <= 32'h0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      be_q       <= be_d;
      maddr_q    <= maddr_d;
      mwdata_q   <= mwdata_d;
      ctrl_q     <= ctrl_d;
      k_q        <= k_d;
      rt_q       <= rt_d;
      rdata_q    <= rdata_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Load extraction: one right shift by the lane offset serves half, byte and LWR.
  assign sh    = {k_q, 3'b000};
  assign shinv = {~k_q, 3'b000};
  assign rsh   = rdata_q >> sh;

  always_comb begin
    ld_val = 32'h0;
    case (ctrl_q)
      3'd1: ld_val = rdata_q;
      3'd2: ld_val = {{16{rsh[15]}}, rsh[15:0]};
      3'd6: ld_val = {16'h0, rsh[15:0]};
      3'd3: ld_val = {{24{rsh[7]}}, rsh[7:0]};
      3'd7: ld_val = {24'h0, rsh[7:0]};
      3'd4: ld_val = (rdata_q << shinv) | (rt_q & ~(32'hFFFF_FFFF << shinv));
      3'd5: ld_val = rsh | (rt_q & ~(32'hFFFF_FFFF >> sh));
      default: ld_val = 32'h0;
    endcase
  end

  assign stall      = !reset && (accept || (state_q == ACCESS));
  assign mem_req    = (state_q == ACCESS);
  assign resp_valid = (state_q == DONE);
  assign load_data  = ((state_q == DONE) && !we_q) ? ld_val : 32'h0;
  assign addr_err   = addr_err_q;
  assign bus_err    = bus_err_q;
  assign mem_we     = we_q;
  assign mem_be     = be_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = mwdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a scoreboard queue holds the expected load_data
// for each accepted access and is drained when resp_valid pulses.
module tb_lsu_mem_port;
  localparam int MAX_WAIT = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  sl_ctrl = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rt_old = 32'h0;
  logic        stall, resp_valid, addr_err, bus_err, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  lsu_mem_port #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .sl_ctrl(sl_ctrl), .addr(addr), .wdata(wdata), .rt_old(rt_old),
    .stall(stall), .resp_valid(resp_valid), .load_data(load_data),
    .addr_err(addr_err), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".stall"}, 32'(stall), 32'h0);
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'h0);
    chk({tag, ".load_data"}, load_data, 32'h0);
    chk({tag, ".addr_err"}, 32'(addr_err), 32'h0);
    chk({tag, ".bus_err"}, 32'(bus_err), 32'h0);
    chk({tag, ".mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, ".mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, ".mem_be"}, 32'(mem_be), 32'h0);
    chk({tag, ".mem_addr"}, mem_addr, 32'h0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'h0);
  endtask

  // One complete access; memory answers after `waits` request cycles without ready.
  task automatic run_access(input string tag, input logic we, input logic [2:0] ctrl,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rt,
                            input logic [31:0] rd, input int waits, input logic [3:0] ebe,
                            input logic [31:0] ewd, input logic [31:0] eld);
    int req_cycles;
    int stalls;
    bit seen;
    exp_q.push_back(eld);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; sl_ctrl = ctrl; addr = a; wdata = wd; rt_old = rt;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    req_cycles = 0; stalls = 0; seen = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      #1;
      if (stall) stalls++;
      if (mem_req) begin
        if (req_cycles == 0) begin
          chk({tag, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
          chk({tag, ".mem_be"}, 32'(mem_be), 32'(ebe));
          chk({tag, ".mem_we"}, 32'(mem_we), 32'(we));
          if (we) chk({tag, ".mem_wdata"}, mem_wdata, ewd);
        end
        mem_ready = (req_cycles == waits);
        mem_rdata = rd;
        req_cycles++;
      end else begin
        mem_ready = 1'b0;
      end
      if (resp_valid) begin
        seen = 1'b1;
        req_valid = 1'b0;
        chk({tag, ".sb_size"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) chk({tag, ".load_data"}, load_data, exp_q.pop_front());
        chk({tag, ".stall_cycles"}, 32'(stalls), 32'(waits + 2));
        chk({tag, ".stall_in_done"}, 32'(stall), 32'h0);
      end
      @(negedge clk);
    end
    chk({tag, ".resp_seen"}, 32'(seen), 32'h1);
    req_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen_be;
    bit seen_resp;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check_all_zero("reset_state");

    // Reset mid-access abandons it.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; sl_ctrl = 3'd1; addr = 32'h300;
    @(negedge clk);
    #1 chk("rst_mid.pre_req", 32'(mem_req), 32'h1);
    reset = 1'b1; req_valid = 1'b0; sl_ctrl = 3'd0;
    @(negedge clk);
    #1 check_all_zero("rst_mid");
    reset = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    seen_resp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1 if (resp_valid) seen_resp = 1'b1;
    end
    chk("rst_mid.no_resp", 32'(seen_resp), 32'h0);

    // Loads
    run_access("lw",  1'b0, 3'd1, 32'h104, 32'h0, 32'h0, 32'hDEADBEEF, 3, 4'b1111, 32'h0, 32'hDEADBEEF);
    run_access("lb",  1'b0, 3'd3, 32'h103, 32'h0, 32'h0, 32'h80FF1234, 0, 4'b1111, 32'h0, 32'hFFFFFF80);
    run_access("lbu", 1'b0, 3'd7, 32'h103, 32'h0, 32'h0, 32'h80FF1234, 1, 4'b1111, 32'h0, 32'h00000080);
    run_access("lh",  1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 32'h80FF1234, 0, 4'b1111, 32'h0, 32'hFFFF80FF);
    run_access("lhu", 1'b0, 3'd6, 32'h102, 32'h0, 32'h0, 32'h80FF1234, 2, 4'b1111, 32'h0, 32'h000080FF);
    run_access("lb0", 1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 32'h80FF1234, 0, 4'b1111, 32'h0, 32'h00000034);
    run_access("lwl", 1'b0, 3'd4, 32'h201, 32'h0, 32'hAABBCCDD, 32'h44332211, 0, 4'b1111, 32'h0, 32'h2211CCDD);
    run_access("lwr", 1'b0, 3'd5, 32'h201, 32'h0, 32'hAABBCCDD, 32'h44332211, 1, 4'b1111, 32'h0, 32'hAA443322);
    run_access("lwl3", 1'b0, 3'd4, 32'h203, 32'h0, 32'hAABBCCDD, 32'h44332211, 0, 4'b1111, 32'h0, 32'h44332211);

    // Stores
    run_access("sb",  1'b1, 3'd3, 32'h101, 32'h000000AB, 32'h0, 32'h0, 0, 4'b0010, 32'hABABABAB, 32'h0);
    run_access("sh",  1'b1, 3'd2, 32'h102, 32'h0000BEEF, 32'h0, 32'h0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0);
    run_access("sw",  1'b1, 3'd1, 32'h108, 32'hCAFEF00D, 32'h0, 32'h0, 0, 4'b1111, 32'hCAFEF00D, 32'h0);
    run_access("swl", 1'b1, 3'd4, 32'h201, 32'h11223344, 32'h0, 32'h0, 0, 4'b0011, 32'h00001122, 32'h0);
    run_access("swr", 1'b1, 3'd5, 32'h201, 32'h11223344, 32'h0, 32'h0, 0, 4'b1110, 32'h22334400, 32'h0);
    run_access("sb7", 1'b1, 3'd7, 32'h103, 32'h0000005A, 32'h0, 32'h0, 0, 4'b1000, 32'h5A5A5A5A, 32'h0);

    // Misaligned word load
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; sl_ctrl = 3'd1; addr = 32'h102;
    #1 chk("lw_mis.stall", 32'(stall), 32'h0);
    @(negedge clk);
    #1 chk("lw_mis.addr_err", 32'(addr_err), 32'h1);
    chk("lw_mis.mem_req", 32'(mem_req), 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    #1 chk("lw_mis.addr_err_clr", 32'(addr_err), 32'h0);
    chk("lw_mis.mem_req2", 32'(mem_req), 32'h0);

    // Misaligned halfword store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; sl_ctrl = 3'd2; addr = 32'h101;
    #1 chk("sh_mis.stall", 32'(stall), 32'h0);
    @(negedge clk);
    #1 chk("sh_mis.addr_err", 32'(addr_err), 32'h1);
    req_valid = 1'b0;

    // sl_ctrl = 0 is not an access
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; sl_ctrl = 3'd0; addr = 32'h100;
    #1 chk("none.stall", 32'(stall), 32'h0);
    @(negedge clk);
    #1 chk("none.mem_req", 32'(mem_req), 32'h0);
    chk("none.addr_err", 32'(addr_err), 32'h0);
    req_valid = 1'b0;

    // Timeout on a store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; sl_ctrl = 3'd1; addr = 32'h400; wdata = 32'h12345678;
    mem_ready = 1'b0;
    cnt = 0; seen_be = 1'b0; seen_resp = 1'b0;
    for (int c = 0; c < 400 && !seen_be; c++) begin
      #1;
      if (mem_req) cnt++;
      if (resp_valid) seen_resp = 1'b1;
      if (bus_err) begin
        seen_be = 1'b1;
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("bus.err_seen", 32'(seen_be), 32'h1);
    chk("bus.req_cycles", 32'(cnt), 32'(MAX_WAIT));
    #1 chk("bus.err_pulse", 32'(bus_err), 32'h0);
    chk("bus.mem_req", 32'(mem_req), 32'h0);
    chk("bus.stall", 32'(stall), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 if (resp_valid) seen_resp = 1'b1;
    end
    chk("bus.no_resp", 32'(seen_resp), 32'h0);
    chk("sb.empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Memory-side responder for the load/store control bundle produced by instruction decode: memory write enable (`req_we`) and the 3-bit size/alignment code (`sl_ctrl`).
- Takes one load/store request per access from the MEM stage.
- Runs a handshake with a data memory that has variable latency. Stores get byte enables and lane-shifted write data; loads get sign/zero extension and the LWL/LWR merge.
- Stalls the pipeline while an access is outstanding. Flags misaligned accesses and memory timeouts.

Parameters:
- MAX_WAIT, 255: cycles `mem_req` may stay high without `mem_ready` before a bus error is flagged.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk, input, 1: clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- req_valid, input, 1: MEM stage holds a load/store; held stable while `stall`=1.
- req_we, input, 1: 1 = store, 0 = load.
- sl_ctrl, input, 3: access code. 0 = none, 1 word, 2 half, 3 byte, 4 word-left, 5 word-right, 6 half-unsigned, 7 byte-unsigned.
- addr, input, 32: byte address computed by the ALU.
- wdata, input, 32: store data (rt).
- rt_old, input, 32: current rt value, used for the LWL/LWR merge.
- stall, output, 1: freeze the pipeline.
- resp_valid, output, 1: one-cycle pulse; the access has completed.
- load_data, output, 32: final register write-back value, valid when `resp_valid`=1.
- addr_err, output, 1: one-cycle pulse on a misaligned request.
- bus_err, output, 1: one-cycle pulse on a timeout.
- mem_req, output, 1: memory request strobe.
- mem_we, output, 1: memory write.
- mem_be, output, 4: byte enables; bit i = byte lane i (little-endian).
- mem_addr, output, 32: word address, `{addr[31:2],2'b00}`.
- mem_wdata, output, 32: lane-aligned store data.
- mem_ready, input, 1: memory accepts or completes the request this cycle.
- mem_rdata, input, 32: read word, valid with `mem_ready`.

Behaviour:
- Reset (synchronous): state = IDLE. Every output is 0; the wait counter is 0. A reset taken mid-access abandons the access: `mem_req` is 0 from the next edge and no response is produced.
- A request with `sl_ctrl`=0 or `req_valid`=0 is ignored and `stall` stays 0.
- States: IDLE, ACCESS, DONE.
- IDLE, valid request, misaligned:
  - Misaligned means word with `addr[1:0]`≠0, or half/half-unsigned with `addr[0]`=1.
  - Pulse `addr_err` next cycle, issue no memory access, stay in IDLE. `stall` is 0.
- IDLE, valid aligned request:
  - `stall`=1 combinationally in the same cycle.
  - Register `mem_addr`, `mem_we`, `mem_be`, `mem_wdata`, `sl_ctrl`, `addr[1:0]`, `rt_old`; go to ACCESS.
  - `mem_req`=1 from the following cycle.
- ACCESS:
  - `stall`=1 and `mem_req`=1; outputs are held stable.
  - On `mem_ready`=1: capture `mem_rdata`, drop `mem_req` next cycle, go to DONE.
  - Otherwise increment the counter. On reaching MAX_WAIT: pulse `bus_err`, drop `mem_req`, go to IDLE with no `resp_valid`.
- DONE: `resp_valid`=1 and `stall`=0 for exactly one cycle, `load_data` valid, then IDLE. The pipeline advances on this cycle. Minimum latency is therefore accept → ACCESS → DONE = 2 stall cycles when memory is zero-wait.
- Store lanes (k = `addr[1:0]`):
  - word: be=1111, data=wdata.
  - half: be=0011<<k, data=wdata[15:0] replicated.
  - byte: be=0001<<k, data=wdata[7:0] replicated.
  - word-left (SWL): be = lanes 0..k, data = wdata>>(8*(3-k)).
  - word-right (SWR): be = lanes k..3, data = wdata<<(8*k).
  - Codes 6/7 with `req_we`=1 behave as 2/3.
- Load extraction (r = captured rdata):
  - word: r.
  - half: sign-extend r[16*addr[1]+:16]; half-unsigned zero-extends the same field.
  - byte: sign-extend r[8k+:8]; byte-unsigned zero-extends it.
  - LWL: (r<<(8*(3-k))) | (rt_old & ((1<<(8*(3-k)))-1)).
  - LWR: (r>>(8*k)) | (rt_old & ~(32'hFFFFFFFF>>(8*k))).
- Loads drive `mem_be`=1111.
- For stores `load_data` is 0, but `resp_valid` still pulses.
- Requests presented while in ACCESS or DONE are not re-accepted; `stall` guarantees the request is stable, and a new request is accepted only in IDLE.

Test Plan:
- Reset asserted during ACCESS with `mem_ready`=0 → next cycle `mem_req`=0, `stall`=0, all outputs 0; a later `mem_ready` pulse produces no `resp_valid`.
- LW at addr 0x104, `mem_ready` after 3 wait cycles, rdata 0xDEADBEEF → `mem_addr`=0x104, be=1111; `stall` high 5 cycles; `resp_valid` with `load_data`=0xDEADBEEF.
- LB / LBU at addr 0x103, rdata 0x80FF1234 → `load_data` 0xFFFFFF80 / 0x00000080; LH at 0x102 → 0xFFFF80FF.
- SB at 0x101 with wdata 0x000000AB → `mem_be`=0010, `mem_wdata`=0xABABABAB, `mem_we`=1; SH at 0x102 → be=1100.
- LWL k=1, rdata 0x44332211, rt_old 0xAABBCCDD → 0x2211CCDD; LWR k=1 → 0xAA443322; SWL k=1 with wdata 0x11223344 → be=0011, data=0x00001122; SWR k=1 → be=1110, data=0x22334400.
- LW at 0x102 → `addr_err` pulse, `mem_req` never asserted. Store with `mem_ready` held 0 → `bus_err` after MAX_WAIT cycles, return to IDLE, no `resp_valid`.
